// File: rtl/instr_encoder.sv
// RV32I instruction encoder.
// Packs decoded instruction fields into a 32-bit word, tags each word with a
// sequential instruction-memory address, and flags immediates that do not fit
// the selected format. One registered output stage with valid/ready handshake.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [2:0]  FMT_R    = 3'd0;
  localparam logic [2:0]  FMT_I    = 3'd1;
  localparam logic [2:0]  FMT_S    = 3'd2;
  localparam logic [2:0]  FMT_B    = 3'd3;
  localparam logic [2:0]  FMT_U    = 3'd4;
  localparam logic [2:0]  FMT_J    = 3'd5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

  // Field placement for each format; illegal formats become a NOP.
  function automatic logic [31:0] encode_word(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] i
  );
    logic [31:0] w;
    case (f)
      FMT_R:   w = {f7, r2, r1, f3, d, op};
      FMT_I:   w = {i[11:0], r1, f3, d, op};
      FMT_S:   w = {i[11:5], r2, r1, f3, i[4:0], op};
      FMT_B:   w = {i[12], i[10:5], r2, r1, f3, i[4:1], i[11], op};
      FMT_U:   w = {i[31:12], d, op};
      FMT_J:   w = {i[20], i[10:1], i[11], i[19:12], d, op};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

  // An immediate fits a signed field when every bit above the field's sign
  // bit equals that sign bit; B/J offsets must additionally be even.
  function automatic logic field_error(input logic [2:0] f, input logic [31:0] i);
    logic e;
    case (f)
      FMT_R:   e = 1'b0;
      FMT_I,
      FMT_S:   e = !((&i[31:11]) || !(|i[31:11]));
      FMT_B:   e = !((&i[31:12]) || !(|i[31:12])) || i[0];
      FMT_U:   e = (i[11:0] != 12'd0);
      FMT_J:   e = !((&i[31:20]) || !(|i[31:20])) || i[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W:0]   count_q,     count_d;
  logic              full_q,      full_d;
  logic              err_q,       err_d;
  logic [ADDR_W-1:0] err_addr_q,  err_addr_d;

  logic        accept;
  logic [31:0] enc_word;
  logic        enc_err;

  // start blocks acceptance so a restart never races with a new word.
  assign in_ready = !start && !full_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign enc_word = encode_word(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
  assign enc_err  = field_error(fmt, imm);

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign full      = full_q;
  assign count     = count_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

  // Next-state for the output stage and the program counters/flags.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;

    // Output register: load on accept (replaces a draining word), else drain.
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_addr_d  = addr_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Counters and flags: start restarts the program, a pending word is untouched.
    if (start) begin
      addr_d     = {ADDR_W{1'b0}};
      count_d    = {(ADDR_W+1){1'b0}};
      full_d     = 1'b0;
      err_d      = 1'b0;
      err_addr_d = {ADDR_W{1'b0}};
    end else if (accept) begin
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
      full_d  = ((count_q + 1'b1) == DEPTH_CNT);
      if (enc_err && !err_q) begin
        err_d      = 1'b1;
        err_addr_d = addr_q;
      end else begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // State registers with asynchronous reset that also discards a pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_addr_q  <= {ADDR_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      count_q     <= {(ADDR_W+1){1'b0}};
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= {ADDR_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- RV32I instruction encoder: packs decoded fields (format, opcode, registers, funct3/funct7, 32-bit immediate) into a 32-bit instruction word.
- Each word is tagged with a sequential instruction-memory word address.
- Sits between the test/program-loader front end and instruction memory; it is the inverse of the core's immediate-extraction path.
- Valid/ready on both sides, one output register stage, immediate range checking, address counter with full detection.

Parameters:
ADDR_W, 8, width of output word address
DEPTH, 256, max instructions per program (must be <= 2^ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse: restart program at address 0, clear flags
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
opcode  in  7  instr[6:0]
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25] (R only)
imm  in  32  signed immediate (U: full value with low 12 bits zero)
out_valid  out  1  out_instr/out_addr valid
out_ready  in  1  downstream accepts
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  word address of out_instr
full  out  1  DEPTH instructions issued since start/reset
count  out  ADDR_W+1  instructions accepted since start/reset
err  out  1  sticky: any range/format error since start/reset
err_addr  out  ADDR_W  address of first erroneous instruction

Behaviour:
- Reset (async, immediate): out_valid=0, out_instr=0, out_addr=0, full=0, count=0, err=0, err_addr=0, internal address=0.
- in_ready = !start && !full && (!out_valid || out_ready).
- Accept when in_valid && in_ready.
- Latency 1: on accept, the output register loads the encoded word and the current address on the next edge. out_valid=1, address++, count++.
- If out_valid && out_ready with no accept: out_valid clears.
- Outputs hold stable while out_valid && !out_ready.
- Encoding (bit positions MSB..LSB):
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - Unused fields for a format are ignored.
- Range checks on accept; violation sets err. The word is still emitted, with immediate bits truncated per the field map.
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
- Illegal fmt (6,7): emit 0x00000013 (NOP) and set err.
- err_addr captures the address of the first erroneous word only; it is frozen while err=1.
- full sets when count reaches DEPTH after an accept. While full, in_ready=0. The final word still drains normally.
- Address wraps only via start; there is no silent wrap.
- start (synchronous):
  - Next edge: address=0, count=0, full=0, err=0, err_addr=0.
  - in_ready=0 that cycle, so no accept coincides with start.
  - A pending output word is unaffected and still delivered with its old address.
- Simultaneous drain and accept: out_valid stays 1 and the new word replaces the old with no bubble.
- rst mid-transfer: pending output is discarded immediately and all state returns to reset values.

Test Plan:
- ADDI x1,x0,5 (fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5) after reset, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0, count=1, err=0.
- Back-to-back ADD x3,x1,x2 (fmt=0, op=0x33, f7=0) then SW x2,8(x1) (fmt=2, op=0x23, f3=2, imm=8) -> 0x002081B3 @addr0 then 0x0020A423 @addr1 on consecutive cycles, no bubble.
- BEQ x1,x2,-4 (fmt=3, op=0x63, imm=0xFFFFFFFC) -> 0xFE208EE3, err=0. Then ADDI imm=4096 -> out_instr=0x00000093, err=1, err_addr=1. A further bad word leaves err_addr=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable. out_ready=1 -> held word drains, next input accepted the same cycle.
- DEPTH=4 override, 4 accepts -> full=1, count=4, in_ready=0. start pulse -> full=0, count=0, err=0, next word emitted at out_addr=0.
- fmt=7 -> out_instr=0x00000013, err=1. Assert rst while out_valid=1 -> out_valid=0 and all outputs 0 without waiting for a clock edge.
